ann: RTL and testbench
======================

# ann

Single-hidden-layer feed-forward neural network with online training, predicting the next day's maximum temperature from the four previous days. It holds 40 signed fixed-point weights (4×8 input→hidden, 8 hidden→output), runs one inference per request, applies one gradient-style update per training request, and streams its weight set in and out over shared 156-bit buses. It sits between the weight-file host and the prediction logger.

## Interface
- INPUT_SIZE, 13: bus width factor; all data buses are INPUT_SIZE*12 = 156 bits.
- INPUT_NUM, 4: input count. NEURON_NUM, 8: hidden neurons.
- LR_OUT_SHIFT, 27: output-weight learning-rate shift. LR_HID_SHIFT, 26: hidden-weight learning-rate shift.
- Clk  in  1  single clock, rising-edge.
- Reset_l  in  1  reset, asynchronous, active-low.
- Temperature_in_0..3  in  156 each  day t..t+3 max temperature, signed integer °C. Bits [31:0] are used and the rest are ignored.
- Weight_in  in  156  weight upload word, signed milli-units, bits [31:0].
- Target  in  156  actual day t+4 temperature, signed integer °C, bits [31:0].
- training_enable_h  in  1  request one training update.
- tb_rev_ready_h  in  1  inputs valid; request inference.
- Weight_Save_enable  in  1  upload weights.
- Weight_Load_enable  in  1  read back weights.
- Data_out  out  156  prediction in milli-°C, signed 32-bit, sign-extended.
- New_weight_out  out  156  weight readback word, signed 32-bit, sign-extended.
- Ready_Signal  out  1  Data_out valid.

## Operation
- Weight array W[0..39], each 32-bit signed, value/1000 = real weight.
  - Index k = 4*j + i is input i → neuron j.
  - Index 32 + j is V_j, neuron j → output.
- Upload: while Weight_Save_enable=1, each rising edge writes Weight_in[31:0] to W[wptr], then wptr++.
  - wptr clears to 0 whenever the enable is low.
  - Writes at wptr ≥ 40 are dropped.
- Readback: while Weight_Load_enable=1, each rising edge registers New_weight_out ← W[rptr], then rptr++.
  - rptr clears to 0 whenever the enable is low.
  - At rptr ≥ 40, output 0.
- Inference starts on a rising edge of tb_rev_ready_h (0→1 as sampled on Clk).
  - h_j = ReLU(Σ_i W[4j+i]·x_i), 64-bit signed, scale ×1000.
  - y = (Σ_j V_j·h_j)/1000, signed division truncating toward zero, saturated to signed 32-bit.
  - Data_out ← y; h_j, x_i and y are retained for training.
- Training starts on training_enable_h=1 sampled in IDLE.
  - e = Target·1000 − y (64-bit signed).
  - V_j += (e·h_j) >>> LR_OUT_SHIFT.
  - If h_j > 0: W[4j+i] += (e·V_j_old·x_i) >>> LR_HID_SHIFT; otherwise W[4j+i] is unchanged.
  - Shifts are arithmetic (floor). All 40 updates are computed in parallel from the pre-update values.
  - Results saturate to signed 32-bit.
- FSM states and transitions:
  - IDLE → INF_HID → INF_OUT → IDLE.
  - IDLE → TRN_ERR → TRN_UPD → IDLE.
- Priority in IDLE: Weight_Save_enable > inference request > training request.
  - Requests arriving while not in IDLE, or while a save is active, are ignored.
  - Readback is independent of the FSM.
- Ready_Signal is set when INF_OUT registers Data_out. It clears on the next accepted inference request or on training start.

## Timing
- Reset (async assert, sync release) clears:
  - W and the stored h, x, y values;
  - Data_out = 0 and New_weight_out = 0;
  - Ready_Signal = 0, both pointers = 0, FSM = IDLE.
- Inference latency: 3 rising edges from the edge that samples tb_rev_ready_h high to Data_out valid.
  - Edge 1 latches inputs; edge 2 registers h_j; edge 3 registers Data_out and sets Ready_Signal.
- Training latency: 2 edges after the request edge. W is stable by the third edge.
- Upload: first word written on the first edge with the enable high. Readback: W[0] is presented after the first enabled edge, then one word per edge.
- Reset mid-operation aborts immediately; no partial update persists.

## Test plan
- Reset: assert Reset_l=0 asynchronously -> Data_out=0, New_weight_out=0, Ready_Signal=0 without waiting for a clock edge.
- Upload/readback: save W[k]=k+1 for 40 cycles, then Load for 40 cycles -> New_weight_out reads 1..40 in order; 41st read returns 0.
- Inference: all W[i,j]=1000, V_j=125, inputs 20,21,22,23 -> h_j=86000, Data_out=86000 three edges after the request, Ready_Signal=1.
- Training, zero error: same state, Target=86 -> all 40 weights are unchanged on readback.
- Training, negative error: same state, Target=80 -> e=−6000; each V_j=121, each W[i,j]=999 (floor shifts).
- ReLU: all W[i,j]=−1000, inputs positive -> Data_out=0; training with Target=30 changes no W[i,j] and no V_j.

Source files
------------

// File: rtl/ann.sv
// ann: single-hidden-layer feed-forward network (4 inputs, 8 ReLU hidden neurons,
// 1 linear output) with online training and a streamed weight upload/readback port.
//   Clk, Reset_l                 clock, async active-low reset
//   Temperature_in_0..3          day t..t+3 temperatures (bits [31:0], signed degC)
//   Weight_in                    upload word (bits [31:0], signed milli-units)
//   Target                       day t+4 temperature for training (bits [31:0])
//   training_enable_h            request one training update
//   tb_rev_ready_h               rising edge requests one inference
//   Weight_Save_enable           stream weights in, one per edge
//   Weight_Load_enable           stream weights out, one per edge
//   Data_out                     prediction in milli-degC, sign-extended
//   New_weight_out               readback word, sign-extended
//   Ready_Signal                 Data_out valid
module ann #(
  parameter int unsigned INPUT_SIZE   = 13,
  parameter int unsigned INPUT_NUM    = 4,
  parameter int unsigned NEURON_NUM   = 8,
  parameter int unsigned LR_OUT_SHIFT = 27,
  parameter int unsigned LR_HID_SHIFT = 26
) (
  input  logic                    Clk,
  input  logic                    Reset_l,
  input  logic [INPUT_SIZE*12-1:0] Temperature_in_0,
  input  logic [INPUT_SIZE*12-1:0] Temperature_in_1,
  input  logic [INPUT_SIZE*12-1:0] Temperature_in_2,
  input  logic [INPUT_SIZE*12-1:0] Temperature_in_3,
  input  logic [INPUT_SIZE*12-1:0] Weight_in,
  input  logic [INPUT_SIZE*12-1:0] Target,
  input  logic                    training_enable_h,
  input  logic                    tb_rev_ready_h,
  input  logic                    Weight_Save_enable,
  input  logic                    Weight_Load_enable,
  output logic [INPUT_SIZE*12-1:0] Data_out,
  output logic [INPUT_SIZE*12-1:0] New_weight_out,
  output logic                    Ready_Signal
);

  localparam int unsigned BUS_W  = INPUT_SIZE * 12;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned HID_W  = 64;
  localparam int unsigned ACC_W  = 128;
  localparam int unsigned V_BASE = INPUT_NUM * NEURON_NUM;
  localparam int unsigned W_NUM  = V_BASE + NEURON_NUM;
  localparam int unsigned PTR_W  = $clog2(W_NUM + 1);

  typedef enum logic [2:0] {IDLE, INF_HID, INF_OUT, TRN_ERR, TRN_UPD} state_t;

  state_t state, state_nxt;

  logic signed [WORD_W-1:0] w_mem  [W_NUM];
  logic signed [WORD_W-1:0] x_q    [INPUT_NUM];
  logic signed [HID_W-1:0]  h_q    [NEURON_NUM];
  logic signed [WORD_W-1:0] y_q;
  logic signed [HID_W-1:0]  e_q;
  logic                     rdy_q;
  logic [PTR_W-1:0]         wptr, rptr;

  logic signed [WORD_W-1:0] temp_c   [INPUT_NUM];
  logic signed [HID_W-1:0]  h_nxt_c  [NEURON_NUM];
  logic signed [WORD_W-1:0] y_nxt_c;
  logic signed [HID_W-1:0]  e_nxt_c;
  logic signed [WORD_W-1:0] upd_nxt_c [W_NUM];
  logic                     inf_req_c, start_inf_c, start_trn_c;

  // Clamp a wide signed value to the signed 32-bit range
  function automatic logic signed [WORD_W-1:0] sat32(input logic signed [ACC_W-1:0] v);
    if ((&v[ACC_W-1:WORD_W-1]) || !(|v[ACC_W-1:WORD_W-1]))
      return v[WORD_W-1:0];
    else if (v[ACC_W-1])
      return {1'b1, {(WORD_W-1){1'b0}}};
    else
      return {1'b0, {(WORD_W-1){1'b1}}};
  endfunction

  assign temp_c[0] = $signed(Temperature_in_0[WORD_W-1:0]);
  assign temp_c[1] = $signed(Temperature_in_1[WORD_W-1:0]);
  assign temp_c[2] = $signed(Temperature_in_2[WORD_W-1:0]);
  assign temp_c[3] = $signed(Temperature_in_3[WORD_W-1:0]);

  // Inference is requested by a 0->1 transition of tb_rev_ready_h
  assign inf_req_c = tb_rev_ready_h & ~rdy_q;

  // State register
  always_ff @(posedge Clk or negedge Reset_l) begin
    if (!Reset_l) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state; an active upload blocks both request types
  always_comb begin
    state_nxt   = state;
    start_inf_c = 1'b0;
    start_trn_c = 1'b0;
    case (state)
      IDLE: begin
        if (!Weight_Save_enable) begin
          if (inf_req_c) begin
            state_nxt   = INF_HID;
            start_inf_c = 1'b1;
          end else if (training_enable_h) begin
            state_nxt   = TRN_ERR;
            start_trn_c = 1'b1;
          end
        end
      end
      INF_HID: state_nxt = INF_OUT;
      INF_OUT: state_nxt = IDLE;
      TRN_ERR: state_nxt = TRN_UPD;
      TRN_UPD: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Hidden layer: h_j = ReLU(sum_i W[4j+i] * x_i)
  always_comb begin
    logic signed [HID_W-1:0] hsum;
    hsum = '0;
    for (int j = 0; j < NEURON_NUM; j++) begin
      hsum = '0;
      for (int i = 0; i < INPUT_NUM; i++)
        hsum = hsum + HID_W'(w_mem[INPUT_NUM*j+i]) * HID_W'(x_q[i]);
      h_nxt_c[j] = hsum[HID_W-1] ? '0 : hsum;
    end
  end

  // Output layer: y = sat(sum_j V_j * h_j / 1000), truncating division
  always_comb begin
    logic signed [ACC_W-1:0] osum;
    osum = '0;
    for (int j = 0; j < NEURON_NUM; j++)
      osum = osum + ACC_W'(w_mem[V_BASE+j]) * ACC_W'(h_q[j]);
    y_nxt_c = sat32(osum / ACC_W'(1000));
  end

  assign e_nxt_c = HID_W'($signed(Target[WORD_W-1:0])) * HID_W'(1000) - HID_W'(y_q);

  // Training: all updates derived from the pre-update weights
  always_comb begin
    logic signed [ACC_W-1:0] delta;
    delta = '0;
    for (int j = 0; j < NEURON_NUM; j++) begin
      delta = (ACC_W'(e_q) * ACC_W'(h_q[j])) >>> LR_OUT_SHIFT;
      upd_nxt_c[V_BASE+j] = sat32(ACC_W'(w_mem[V_BASE+j]) + delta);
      for (int i = 0; i < INPUT_NUM; i++) begin
        if (h_q[j] != '0) begin
          delta = (ACC_W'(e_q) * ACC_W'(w_mem[V_BASE+j]) * ACC_W'(x_q[i])) >>> LR_HID_SHIFT;
          upd_nxt_c[INPUT_NUM*j+i] = sat32(ACC_W'(w_mem[INPUT_NUM*j+i]) + delta);
        end else begin
          upd_nxt_c[INPUT_NUM*j+i] = w_mem[INPUT_NUM*j+i];
        end
      end
    end
  end

  // Inference/training pipeline registers and result output
  always_ff @(posedge Clk or negedge Reset_l) begin
    if (!Reset_l) begin
      for (int i = 0; i < INPUT_NUM; i++)  x_q[i] <= '0;
      for (int j = 0; j < NEURON_NUM; j++) h_q[j] <= '0;
      y_q          <= '0;
      e_q          <= '0;
      rdy_q        <= 1'b0;
      Data_out     <= '0;
      Ready_Signal <= 1'b0;
    end else begin
      rdy_q <= tb_rev_ready_h;
      if (start_inf_c) begin
        for (int i = 0; i < INPUT_NUM; i++) x_q[i] <= temp_c[i];
        Ready_Signal <= 1'b0;
      end
      if (start_trn_c) Ready_Signal <= 1'b0;
      if (state == INF_HID)
        for (int j = 0; j < NEURON_NUM; j++) h_q[j] <= h_nxt_c[j];
      if (state == INF_OUT) begin
        y_q          <= y_nxt_c;
        Data_out     <= BUS_W'(y_nxt_c);
        Ready_Signal <= 1'b1;
      end
      if (state == TRN_ERR) e_q <= e_nxt_c;
    end
  end

  // Weight store: training update, then upload stream (upload wins on collision)
  always_ff @(posedge Clk or negedge Reset_l) begin
    if (!Reset_l) begin
      for (int k = 0; k < W_NUM; k++) w_mem[k] <= '0;
      wptr <= '0;
    end else begin
      if (state == TRN_UPD)
        for (int k = 0; k < W_NUM; k++) w_mem[k] <= upd_nxt_c[k];
      if (Weight_Save_enable) begin
        if (wptr < PTR_W'(W_NUM)) begin
          w_mem[wptr] <= $signed(Weight_in[WORD_W-1:0]);
          wptr        <= wptr + PTR_W'(1);
        end
      end else begin
        wptr <= '0;
      end
    end
  end

  // Readback stream, independent of the FSM
  always_ff @(posedge Clk or negedge Reset_l) begin
    if (!Reset_l) begin
      rptr           <= '0;
      New_weight_out <= '0;
    end else if (Weight_Load_enable) begin
      if (rptr < PTR_W'(W_NUM)) begin
        New_weight_out <= BUS_W'(w_mem[rptr]);
        rptr           <= rptr + PTR_W'(1);
      end else begin
        New_weight_out <= '0;
      end
    end else begin
      rptr <= '0;
    end
  end

endmodule

// File: tb/tb_ann.sv
// Self-checking bench for ann: directed scenarios plus randomized rounds against
// an arithmetic reference model of the network.
module tb_ann;

  localparam int unsigned BW = 156;
  typedef logic signed [127:0] wide_t;

  logic          Clk, Reset_l;
  logic [BW-1:0] Temperature_in_0, Temperature_in_1, Temperature_in_2, Temperature_in_3;
  logic [BW-1:0] Weight_in, Target;
  logic          training_enable_h, tb_rev_ready_h, Weight_Save_enable, Weight_Load_enable;
  logic [BW-1:0] Data_out, New_weight_out;
  logic          Ready_Signal;

  ann dut (
    .Clk(Clk), .Reset_l(Reset_l),
    .Temperature_in_0(Temperature_in_0), .Temperature_in_1(Temperature_in_1),
    .Temperature_in_2(Temperature_in_2), .Temperature_in_3(Temperature_in_3),
    .Weight_in(Weight_in), .Target(Target),
    .training_enable_h(training_enable_h), .tb_rev_ready_h(tb_rev_ready_h),
    .Weight_Save_enable(Weight_Save_enable), .Weight_Load_enable(Weight_Load_enable),
    .Data_out(Data_out), .New_weight_out(New_weight_out), .Ready_Signal(Ready_Signal)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int    mw [40];
  int    mx [4];
  longint mh [8];
  int    my;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] sx(input int v);
    return {{(BW-32){v[31]}}, v};
  endfunction

  // Low word carries the value; the ignored upper bits get random junk
  function automatic logic [BW-1:0] junk_word(input int v);
    return {28'($urandom), $urandom, $urandom, $urandom, v};
  endfunction

  function automatic int sat(input wide_t v);
    if (v > wide_t'(2147483647)) return 2147483647;
    if (v < wide_t'(-2147483647 - 1)) return -2147483647 - 1;
    return int'(v);
  endfunction

  function automatic void model_infer();
    wide_t acc;
    for (int j = 0; j < 8; j++) begin
      longint s = 0;
      for (int i = 0; i < 4; i++) s += longint'(mw[4*j+i]) * longint'(mx[i]);
      mh[j] = (s < 0) ? 0 : s;
    end
    acc = 0;
    for (int j = 0; j < 8; j++) acc += wide_t'(mw[32+j]) * wide_t'(mh[j]);
    my = sat(acc / wide_t'(1000));
  endfunction

  function automatic void model_train(input int tgt);
    int     old [40];
    longint e;
    e = longint'(tgt) * 1000 - longint'(my);
    old = mw;
    for (int j = 0; j < 8; j++) begin
      mw[32+j] = sat(wide_t'(old[32+j]) + ((wide_t'(e) * wide_t'(mh[j])) >>> 27));
      if (mh[j] > 0)
        for (int i = 0; i < 4; i++)
          mw[4*j+i] = sat(wide_t'(old[4*j+i]) +
                          ((wide_t'(e) * wide_t'(old[32+j]) * wide_t'(mx[i])) >>> 26));
    end
  endfunction

  // Stream mw in, plus two extra words that must be dropped
  task automatic upload();
    for (int k = 0; k < 42; k++) begin
      @(negedge Clk);
      Weight_Save_enable = 1'b1;
      Weight_in = (k < 40) ? junk_word(mw[k]) : junk_word(int'($urandom));
    end
    @(negedge Clk);
    Weight_Save_enable = 1'b0;
  endtask

  task automatic readback(input string tag);
    @(negedge Clk);
    Weight_Load_enable = 1'b1;
    for (int k = 0; k < 41; k++) begin
      @(negedge Clk);
      check($sformatf("%s_rd%0d", tag, k), New_weight_out, (k < 40) ? sx(mw[k]) : '0);
    end
    Weight_Load_enable = 1'b0;
  endtask

  task automatic infer(input string tag, input int x0, input int x1, input int x2, input int x3);
    int lat;
    mx[0] = x0; mx[1] = x1; mx[2] = x2; mx[3] = x3;
    model_infer();
    @(negedge Clk);
    Temperature_in_0 = junk_word(x0);
    Temperature_in_1 = junk_word(x1);
    Temperature_in_2 = junk_word(x2);
    Temperature_in_3 = junk_word(x3);
    tb_rev_ready_h = 1'b1;
    lat = 0;
    do begin
      @(negedge Clk);
      lat++;
    end while (!Ready_Signal && lat < 12);
    tb_rev_ready_h = 1'b0;
    check({tag, "_lat"}, BW'(lat), BW'(3));
    check({tag, "_rdy"}, BW'(Ready_Signal), BW'(1));
    check({tag, "_y"}, Data_out, sx(my));
  endtask

  task automatic train(input string tag, input int tgt);
    @(negedge Clk);
    Target = junk_word(tgt);
    training_enable_h = 1'b1;
    @(negedge Clk);
    training_enable_h = 1'b0;
    repeat (2) @(negedge Clk);
    check({tag, "_rdyclr"}, BW'(Ready_Signal), BW'(0));
    model_train(tgt);
    readback(tag);
  endtask

  task automatic set_uniform(input int wh, input int vo);
    for (int k = 0; k < 32; k++) mw[k] = wh;
    for (int k = 32; k < 40; k++) mw[k] = vo;
  endtask

  initial begin
    Reset_l = 1'b1;
    Temperature_in_0 = '0; Temperature_in_1 = '0; Temperature_in_2 = '0; Temperature_in_3 = '0;
    Weight_in = '0; Target = '0;
    training_enable_h = 1'b0; tb_rev_ready_h = 1'b0;
    Weight_Save_enable = 1'b0; Weight_Load_enable = 1'b0;
    for (int k = 0; k < 40; k++) mw[k] = 0;
    my = 0;

    #1 Reset_l = 1'b0;
    #1;
    check("rst_data", Data_out, '0);
    check("rst_nwo", New_weight_out, '0);
    check("rst_rdy", BW'(Ready_Signal), BW'(0));
    @(negedge Clk);
    Reset_l = 1'b1;

    // Upload / readback ordering, 41st read is zero
    for (int k = 0; k < 40; k++) mw[k] = k + 1;
    upload();
    readback("seq");

    // Directed inference and training
    set_uniform(1000, 125);
    upload();
    infer("inf_pos", 20, 21, 22, 23);
    train("trn_zero", 86);
    train("trn_neg", 80);
    check("trn_neg_w0", sx(mw[0]), sx(999));
    check("trn_neg_v0", sx(mw[32]), sx(121));

    // ReLU cut-off: negative hidden sums block all updates
    set_uniform(-1000, 125);
    upload();
    infer("inf_relu", 20, 21, 22, 23);
    train("trn_relu", 30);

    // Randomized rounds
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 40; k++) mw[k] = int'($urandom_range(6000)) - 3000;
      upload();
      infer($sformatf("rnd%0d", r),
            int'($urandom_range(70)) - 20, int'($urandom_range(70)) - 20,
            int'($urandom_range(70)) - 20, int'($urandom_range(70)) - 20);
      train($sformatf("rndt%0d", r), int'($urandom_range(70)) - 20);
      infer($sformatf("rndb%0d", r),
            int'($urandom_range(70)) - 20, int'($urandom_range(70)) - 20,
            int'($urandom_range(70)) - 20, int'($urandom_range(70)) - 20);
    end

    // Reset in the middle of an inference, with nonzero outputs held
    @(negedge Clk);
    Weight_Load_enable = 1'b1;
    repeat (3) @(negedge Clk);
    Weight_Load_enable = 1'b0;
    tb_rev_ready_h = 1'b1;
    @(posedge Clk);
    #2 Reset_l = 1'b0;
    #1;
    check("mid_rst_data", Data_out, '0);
    check("mid_rst_nwo", New_weight_out, '0);
    check("mid_rst_rdy", BW'(Ready_Signal), BW'(0));
    tb_rev_ready_h = 1'b0;
    @(negedge Clk);
    Reset_l = 1'b1;
    for (int k = 0; k < 40; k++) mw[k] = 0;
    readback("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
